one_wire_uid_sched: RTL and testbench
=====================================

ONE_WIRE_UID_SCHED -- requirements
Module: one_wire_uid_sched

Interface
REQ-001 SHALL have parameter UID_SERIAL_DATA_WIDTH, default 56: width of one UID payload, in bits.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8: width of the bit counter.
REQ-003 SHALL have parameter START_TIMEOUT, default 4: cycles allowed between sh_data_valid and sh_start_crc rising.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_a and req_b, input, 1 each: level requests, held until granted.
REQ-007 SHALL have ports uid_a and uid_b, input, UID_SERIAL_DATA_WIDTH each: payloads, valid while the matching req is high.
REQ-008 SHALL have ports gnt_a and gnt_b, output, 1 each: one-cycle grant pulses.
REQ-009 SHALL have ports sh_data_valid (output, 1) and sh_uid (output, UID_SERIAL_DATA_WIDTH): load strobe and payload to the shifter.
REQ-010 SHALL have ports sh_start_crc and sh_data_stream, input, 1 each: shifter busy flag and serial bit, LSB first.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, pulse), grant_id (output, 1; 0=A, 1=B), crc_out (output, 8), mismatch_err (output, 1), timeout_err (output, 1, pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, WAIT_START, SHIFT, WAIT_END, DONE and ERR.
- IDLE: if any req is high, pick one winner, pulse its gnt, latch its uid and grant_id, then go to LOAD.
- Arbitration is round-robin: on simultaneous requests the winner is the requester not served last; after reset A is preferred.
REQ-013 LOAD SHALL hold sh_data_valid high for exactly one cycle, with sh_uid equal to the latched uid, then go to WAIT_START.
- sh_uid SHALL hold its value until the next grant.
REQ-014 WAIT_START:
- When sh_start_crc is observed high, go to SHIFT.
- If sh_start_crc is not observed high within START_TIMEOUT cycles, go to ERR.
REQ-015 SHIFT:
- Sample sh_data_stream on the UID_SERIAL_DATA_WIDTH consecutive cycles starting the cycle after sh_start_crc is first seen high.
- Feed each sample to a serial CRC-8 (poly x^8+x^5+x^4+1, init 0x00, LSB first).
- Compare each sample with latched uid[bit_cnt]; any difference sets mismatch_err.
- bit_cnt runs from 0 to UID_SERIAL_DATA_WIDTH-1, then the FSM goes to WAIT_END.
REQ-016 If sh_start_crc falls before all UID_SERIAL_DATA_WIDTH bits are sampled, the FSM SHALL go to ERR.
REQ-017 WAIT_END SHALL wait for sh_start_crc low, then go to DONE.
REQ-018 DONE SHALL pulse done for one cycle, with crc_out valid, then return to IDLE.
- crc_out and mismatch_err SHALL hold until the next grant, which clears them.
REQ-019 ERR SHALL pulse timeout_err for one cycle and return to IDLE; crc_out is not updated.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 Requests arriving while busy SHALL be ignored until IDLE and SHALL NOT be lost while held.
REQ-022 A grant SHALL be issued no earlier than the cycle after done or timeout_err.
REQ-023 Latency from req in IDLE: gnt in the same cycle (registered), sh_data_valid on the next cycle.

Reset
REQ-024 While rst_n is low, the state SHALL be IDLE and all outputs SHALL be 0.
- Reset SHALL clear gnt_a, gnt_b, sh_data_valid, sh_uid, busy, done, grant_id, crc_out, mismatch_err and timeout_err.
- Reset SHALL clear bit_cnt and the timeout counter, and set the round-robin pointer to prefer A.
REQ-025 Reset asserted mid-transfer SHALL abort immediately, with no done or timeout_err pulse after release.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the CRC-8 polynomial constant 8'h8C (reflected) and the UID_SERIAL_DATA_WIDTH default.
REQ-027 The CRC SHALL be the sub-module one_wire_crc8_serial, with ports clk, rst_n, clear, bit_en, bit_in and crc.

Verification
REQ-028 Single transfer: req_a with uid_a=56'h00000001B81C02 and a compliant shifter model -> gnt_a, one sh_data_valid, then done, with crc_out=8'hA2 and mismatch_err=0.
REQ-029 Simultaneous req_a and req_b from reset -> A is served, then B; on the next simultaneous pair, B is served first.
REQ-030 Shifter never raises sh_start_crc -> timeout_err exactly START_TIMEOUT+1 cycles after sh_data_valid, busy falls, and no done.
REQ-031 Model flips stream bit 17 -> done with mismatch_err=1, and crc_out differs from 8'hA2.
REQ-032 sh_start_crc drops after 30 bits -> timeout_err pulse, and crc_out keeps its prior value.
REQ-033 rst_n pulsed low during SHIFT -> all outputs 0 within the cycle, and a fresh req_b afterwards completes normally.

Source files
------------

// File: rtl/one_wire_uid_sched_pkg.sv
// one_wire_uid_sched_pkg: shared FSM states, CRC-8 constants and UID width default
package one_wire_uid_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, SHIFT, WAIT_END, DONE, ERR} state_e;
  localparam logic [7:0] CRC8_POLY = 8'h8C;
  localparam int UID_W_DEFAULT = 56;
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return (crc >> 1) ^ ((crc[0] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/one_wire_uid_sched_crc8.sv
// one_wire_crc8_serial: LSB-first serial Dallas/Maxim CRC-8 accumulator
module one_wire_crc8_serial
  import one_wire_uid_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  logic [7:0] crc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else if (clear) crc_q <= '0;
    else if (bit_en) crc_q <= crc8_step(crc_q, bit_in);
  end
  assign crc = crc_q;
endmodule

// File: rtl/one_wire_uid_sched.sv
// one_wire_uid_sched: round-robin arbiter feeding UIDs to a 1-wire shifter and checking the echoed stream
module one_wire_uid_sched
  import one_wire_uid_sched_pkg::*;
#(
  parameter int UID_SERIAL_DATA_WIDTH = UID_W_DEFAULT,
  parameter int FIFO_WIDTH            = 8,
  parameter int START_TIMEOUT         = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_a,
  input  logic                             req_b,
  input  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_a,
  input  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_b,
  output logic                             gnt_a,
  output logic                             gnt_b,
  output logic                             sh_data_valid,
  output logic [UID_SERIAL_DATA_WIDTH-1:0] sh_uid,
  input  logic                             sh_start_crc,
  input  logic                             sh_data_stream,
  output logic                             busy,
  output logic                             done,
  output logic                             grant_id,
  output logic [7:0]                       crc_out,
  output logic                             mismatch_err,
  output logic                             timeout_err
);
  localparam int IW = $clog2(UID_SERIAL_DATA_WIDTH);
  localparam int TW = $clog2(START_TIMEOUT + 2);
  state_e                           state_q, state_d;
  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_q;
  logic [FIFO_WIDTH-1:0]            bit_cnt_q;
  logic [TW-1:0]                    tmo_q;
  logic [7:0]                       crc_out_q, crc;
  logic gnt_a_q, gnt_b_q, dv_q, done_q, terr_q, grant_id_q, mis_q, pref_b_q;
  logic grant, win_b, bit_en, miss;
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    win_b   = 1'b0;
    bit_en  = 1'b0;
    case (state_q)
      IDLE: begin
        grant   = req_a | req_b;
        win_b   = req_b & (~req_a | pref_b_q);
        state_d = grant ? LOAD : IDLE;
      end
      LOAD:       state_d = WAIT_START;
      WAIT_START: state_d = sh_start_crc ? SHIFT : (tmo_q == TW'(START_TIMEOUT)) ? ERR : WAIT_START;
      SHIFT: begin
        bit_en  = sh_start_crc;
        state_d = !sh_start_crc ? ERR :
                  (bit_cnt_q == FIFO_WIDTH'(UID_SERIAL_DATA_WIDTH - 1)) ? WAIT_END : SHIFT;
      end
      WAIT_END:   state_d = sh_start_crc ? WAIT_END : DONE;
      DONE:       state_d = IDLE;
      ERR:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  assign miss = bit_en & (sh_data_stream ^ uid_q[bit_cnt_q[IW-1:0]]);
  one_wire_crc8_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (grant),
    .bit_en(bit_en),
    .bit_in(sh_data_stream),
    .crc   (crc)
  );
  // crc_out only captures on a clean finish, so an aborted transfer leaves it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      uid_q      <= '0;
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      crc_out_q  <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      dv_q       <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      grant_id_q <= 1'b0;
      mis_q      <= 1'b0;
      pref_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_a_q   <= grant & ~win_b;
      gnt_b_q   <= grant & win_b;
      dv_q      <= state_q == LOAD;
      done_q    <= state_d == DONE;
      terr_q    <= state_d == ERR;
      tmo_q     <= (state_q == WAIT_START) ? tmo_q + 1'b1 : '0;
      bit_cnt_q <= grant ? '0 : bit_cnt_q + FIFO_WIDTH'(bit_en);
      if (grant) begin
        uid_q      <= win_b ? uid_b : uid_a;
        grant_id_q <= win_b;
        pref_b_q   <= ~win_b;
        crc_out_q  <= '0;
        mis_q      <= 1'b0;
      end else begin
        mis_q <= mis_q | miss;
        if (state_d == DONE) crc_out_q <= crc;
      end
    end
  end
  assign gnt_a         = gnt_a_q;
  assign gnt_b         = gnt_b_q;
  assign sh_data_valid = dv_q;
  assign sh_uid        = uid_q;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign grant_id      = grant_id_q;
  assign crc_out       = crc_out_q;
  assign mismatch_err  = mis_q;
  assign timeout_err   = terr_q;
endmodule

// File: tb/tb_one_wire_uid_sched.sv
// tb_one_wire_uid_sched: directed checks of arbitration, CRC, mismatch, timeout and reset behaviour
module tb_one_wire_uid_sched;
  localparam logic [55:0] UA = 56'h00000001B81C02;
  localparam logic [55:0] UB = 56'hC3A55A3C0F1E2D;
  logic clk = 1'b0;
  logic rst_n, req_a, req_b, sh_start_crc, sh_data_stream;
  logic [55:0] uid_a, uid_b, sh_uid;
  logic gnt_a, gnt_b, sh_data_valid, busy, done, grant_id, mismatch_err, timeout_err;
  logic [7:0] crc_out;
  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, terr_cnt = 0, dv_cnt = 0;
  always #5 clk = ~clk;
  one_wire_uid_sched dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .uid_a(uid_a), .uid_b(uid_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sh_data_valid(sh_data_valid), .sh_uid(sh_uid),
    .sh_start_crc(sh_start_crc), .sh_data_stream(sh_data_stream), .busy(busy), .done(done),
    .grant_id(grant_id), .crc_out(crc_out), .mismatch_err(mismatch_err), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
    if (done) done_cnt++;
    if (timeout_err) terr_cnt++;
    if (sh_data_valid) dv_cnt++;
  endtask
  function automatic logic [7:0] crc8_ref(input logic [55:0] d);
    logic [7:0] c;
    logic [55:0] x;
    c = 8'h00;
    x = d;
    for (int i = 0; i < 56; i++) begin
      c = (c[0] ^ x[0]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
      x = x >> 1;
    end
    return c;
  endfunction
  task automatic wait_gnt(output logic ga, output logic gb);
    ga = 1'b0;
    gb = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc;
      if (gnt_a || gnt_b) begin
        ga = gnt_a;
        gb = gnt_b;
        break;
      end
    end
    if (ga) req_a = 1'b0;
    if (gb) req_b = 1'b0;
    if (!(ga || gb)) chk("gnt_seen", 0, 1);
  endtask
  // shifter model: start rises in the load-strobe cycle, bit k follows k+1 cycles later
  task automatic shift_model(input logic [55:0] data, input int n_high, input int flip, input logic start_ever);
    logic [55:0] d;
    logic stop;
    d = data;
    stop = 1'b0;
    cyc;
    chk("dv_pulse", sh_data_valid, 1);
    chk("sh_uid", sh_uid, data);
    if (start_ever) begin
      sh_start_crc = 1'b1;
      for (int k = 0; k <= 56 && !stop; k++) begin
        cyc;
        if (k == n_high) begin
          sh_start_crc = 1'b0;
          stop = 1'b1;
        end else begin
          sh_data_stream = d[0] ^ (k == flip);
          d = d >> 1;
        end
      end
      sh_data_stream = 1'b0;
    end
  endtask
  task automatic wait_end(output logic gd, output logic gt, output int n);
    gd = 1'b0;
    gt = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (done || timeout_err) begin
        gd = done;
        gt = timeout_err;
        n = i;
        break;
      end
      cyc;
    end
    if (!(gd || gt)) chk("end_seen", 0, 1);
  endtask
  task automatic full_xfer(input string tag, input logic exp_b, input logic [55:0] uid);
    logic ga, gb, gd, gt;
    int n;
    wait_gnt(ga, gb);
    chk({tag, "_gnt"}, {ga, gb}, exp_b ? 2'b01 : 2'b10);
    chk({tag, "_gid"}, grant_id, exp_b);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_crc_clr"}, crc_out, 0);
    shift_model(uid, 56, -1, 1'b1);
    wait_end(gd, gt, n);
    chk({tag, "_done"}, {gd, gt}, 2'b10);
    chk({tag, "_crc"}, crc_out, crc8_ref(uid));
    chk({tag, "_mis"}, mismatch_err, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic ga, gb, gd, gt;
    int n, d0, t0;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; uid_a = '0; uid_b = '0;
    sh_start_crc = 1'b0; sh_data_stream = 1'b0;
    cyc; cyc;
    chk("rst_ctl", {gnt_a, gnt_b, sh_data_valid, busy, done, grant_id, mismatch_err, timeout_err}, 0);
    chk("rst_uid", sh_uid, 0);
    chk("rst_crc", crc_out, 0);
    rst_n = 1'b1;
    cyc;
    d0 = dv_cnt;
    uid_a = UA; req_a = 1'b1;
    full_xfer("single", 1'b0, UA);
    chk("single_a2", crc_out, 8'hA2);
    chk("single_dv_cnt", 64'(dv_cnt - d0), 1);
    cyc;
    chk("done_pulse", {done, busy}, 0);
    chk("crc_hold", crc_out, 8'hA2);
    chk("uid_hold", sh_uid, UA);
    rst_n = 1'b0; cyc; rst_n = 1'b1; cyc;
    uid_b = UB; req_a = 1'b1; req_b = 1'b1;
    full_xfer("rr1", 1'b0, UA); req_a = 1'b1;
    full_xfer("rr2", 1'b1, UB); req_b = 1'b1;
    full_xfer("rr3", 1'b0, UA);
    full_xfer("rr4", 1'b1, UB);
    d0 = done_cnt;
    req_a = 1'b1;
    wait_gnt(ga, gb);
    shift_model(UA, 0, -1, 1'b0);
    wait_end(gd, gt, n);
    chk("tmo_err", {gd, gt}, 2'b01);
    chk("tmo_lat", 64'(n), 5);
    cyc;
    chk("tmo_idle", {busy, timeout_err}, 0);
    chk("tmo_no_done", 64'(done_cnt - d0), 0);
    uid_b = UA; req_b = 1'b1;
    wait_gnt(ga, gb);
    chk("flip_gnt", {ga, gb}, 2'b01);
    shift_model(UA, 56, 17, 1'b1);
    wait_end(gd, gt, n);
    chk("flip_done", {gd, gt}, 2'b10);
    chk("flip_mis", mismatch_err, 1);
    chk("flip_ne_a2", crc_out != 8'hA2, 1);
    chk("flip_crc", crc_out, crc8_ref(UA ^ (56'd1 << 17)));
    cyc;
    req_a = 1'b1;
    wait_gnt(ga, gb);
    shift_model(UA, 30, -1, 1'b1);
    wait_end(gd, gt, n);
    chk("drop_err", {gd, gt}, 2'b01);
    chk("drop_crc", crc_out, 0);
    chk("drop_mis", mismatch_err, 0);
    cyc;
    req_a = 1'b1;
    wait_gnt(ga, gb);
    cyc;
    sh_start_crc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc;
      sh_data_stream = ~sh_data_stream;
    end
    cyc;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {gnt_a, gnt_b, sh_data_valid, busy, done, grant_id, mismatch_err, timeout_err}, 0);
    chk("mid_rst_uid", sh_uid, 0);
    chk("mid_rst_crc", crc_out, 0);
    sh_start_crc = 1'b0; sh_data_stream = 1'b0;
    cyc;
    rst_n = 1'b1;
    d0 = done_cnt; t0 = terr_cnt;
    repeat (8) cyc;
    chk("mid_no_done", 64'(done_cnt - d0), 0);
    chk("mid_no_terr", 64'(terr_cnt - t0), 0);
    chk("mid_idle", busy, 0);
    uid_b = UB; req_b = 1'b1;
    full_xfer("post_rst", 1'b1, UB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
